jaxa_timecode_ctrl: RTL
=======================

JAXA_TIMECODE_CTRL -- requirements
Module: jaxa_timecode_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 6: time-code value width, legal 1..30.
REQ-002 SHALL have parameter TIMEOUT, default 255: number of cycles to wait for tick_ack, legal 1..65535.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port address, input, 2: Avalon-MM register select.
REQ-006 SHALL have port chipselect, input, 1: Avalon-MM select.
REQ-007 SHALL have port write_n, input, 1: Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata, input, 32: Avalon-MM write data.
REQ-009 SHALL have port readdata, output, 32: combinational read of the register at address; unused bits 0.
REQ-010 SHALL have port time_out, output, DATA_W: time-code value presented to the SpaceWire core.
REQ-011 SHALL have port flags_out, output, 2: time-code control flags.
REQ-012 SHALL have port tick_out, output, 1: tick request, held high until acknowledged or timed out.
REQ-013 SHALL have port tick_ack, input, 1: one-cycle acceptance strobe from the SpaceWire core.

Function
REQ-014 SHALL decode a register write as chipselect=1 and write_n=0.
REQ-015 SHALL implement addr 0 TIME, DATA_W bits, read/write.
REQ-016 SHALL implement addr 1 CTRL: bit0 SEND (write-1 strobe, reads 0), bit1 AUTO_INC (R/W), bits3:2 FLAGS (R/W).
REQ-017 SHALL implement addr 2 STATUS: bit0 BUSY (RO), bit1 PENDING (RO), bit2 TOERR (sticky, write-1-to-clear).
REQ-018 SHALL implement addr 3 PERIOD, 16 bits R/W; this register exists only per REQ-032.
REQ-019 SHALL use an FSM with states IDLE and REQ; BUSY=1 exactly when the state is REQ.
REQ-020 SHALL, on a start in IDLE (SEND write, PENDING set, or period expiry), latch TIME into time_out and FLAGS into flags_out, and drive tick_out=1 on the next cycle (write at cycle N gives tick_out high at N+1).
REQ-021 SHALL, in REQ, count the cycles for which tick_ack=0; when tick_ack=1 is sampled, go to IDLE with tick_out=0 on the next cycle.
REQ-022 SHALL, on acknowledge with AUTO_INC=1, set TIME to (TIME+1) mod 2^DATA_W, so 2^DATA_W-1 wraps to 0.
REQ-023 SHALL, after TIMEOUT cycles in REQ without acknowledge, drop tick_out, set TOERR, return to IDLE, and leave TIME unchanged.
REQ-024 SHALL give acknowledge priority when tick_ack arrives on the timeout cycle: no TOERR, and the increment applies.
REQ-025 SHALL, on a start request while BUSY, set PENDING; further requests while PENDING is set are dropped.
REQ-026 SHALL, when PENDING is set on return to IDLE, clear PENDING and start the next transfer with the current TIME, going back to REQ with no IDLE dwell beyond one cycle.
REQ-027 SHALL, on a TIME write while BUSY, leave time_out unchanged and use the new TIME at the next start.
REQ-028 SHALL, on a TIME write and an auto-increment in the same cycle, apply the written value.
REQ-029 SHALL ignore tick_ack while in IDLE.

Reset
REQ-030 SHALL, on reset_n=0 at a clock edge, set TIME=0, CTRL=0, PENDING=0, TOERR=0, PERIOD=0, timers=0, state=IDLE, tick_out=0, time_out=0, flags_out=0.
REQ-031 SHALL, on reset during REQ, deassert tick_out on the next edge with no increment and no TOERR.

Configuration
REQ-032 SHALL, with macro JAXA_TIMECODE_PERIODIC_EN defined, include PERIOD and a 16-bit down-counter: PERIOD=0 disables it; otherwise it reloads PERIOD-1 and issues one start request every PERIOD cycles, with a PERIOD write reloading the counter.
REQ-033 SHALL, without JAXA_TIMECODE_PERIODIC_EN, omit the counter, read addr 3 as 0, and ignore writes to addr 3.

Verification
REQ-034 SHALL cover: write TIME=0x15, then write CTRL=0x1 -> tick_out=1 the next cycle with time_out=0x15; ack after 3 cycles -> tick_out=0 one cycle later, TIME stays 0x15.
REQ-035 SHALL cover: AUTO_INC=1, TIME=0x3F (DATA_W=6), SEND, ack -> TIME reads 0x00.
REQ-036 SHALL cover: TIMEOUT=4, SEND, no ack -> tick_out drops after 4 REQ cycles and STATUS=0x4; writing STATUS=0x4 -> STATUS=0x0.
REQ-037 SHALL cover: three SEND writes while BUSY -> PENDING=1 and exactly two ticks total; the second tick carries the incremented TIME when AUTO_INC=1.
REQ-038 SHALL cover: with JAXA_TIMECODE_PERIODIC_EN, PERIOD=10 and AUTO_INC=1 with immediate ack -> ticks 10 cycles apart and TIME increments by 1 each; without the macro, PERIOD reads 0.
REQ-039 SHALL cover: reset_n=0 during REQ -> tick_out=0 after the edge and all registers read 0.

Source files
------------

// File: rtl/jaxa_timecode_ctrl.sv
// ---------------------------------------------------------------------------
// jaxa_timecode_ctrl
//
// Avalon-MM controlled SpaceWire time-code transmitter front end. Software
// loads a time value and control flags. Each start request presents them to
// the SpaceWire core through time_out/flags_out and raises tick_out until
// the core acknowledges or the acknowledge timeout expires. An optional
// auto-increment advances the time value on every acknowledged tick.
//
// Optional feature macro: JAXA_TIMECODE_PERIODIC_EN
//   When this macro is defined, the PERIOD register (addr 3) and a 16-bit
//   down-counter are added. The counter issues a start request every PERIOD
//   cycles. When the macro is undefined, addr 3 reads 0 and writes to it are
//   ignored.
//
// Register map (32-bit readdata, unused bits read 0):
//   addr 0 TIME   [DATA_W-1:0] R/W
//   addr 1 CTRL   bit0 SEND (write-1 strobe, reads 0), bit1 AUTO_INC,
//                 bits3:2 FLAGS
//   addr 2 STATUS bit0 BUSY (RO), bit1 PENDING (RO), bit2 TOERR (W1C)
//   addr 3 PERIOD [15:0] (only with JAXA_TIMECODE_PERIODIC_EN)
//
// Ports:
//   clk        - sole clock, rising edge
//   reset_n    - synchronous active-low reset
//   address    - register select
//   chipselect - Avalon-MM select
//   write_n    - Avalon-MM write strobe, active-low
//   writedata  - Avalon-MM write data
//   readdata   - combinational read of the selected register
//   time_out   - time-code value presented to the SpaceWire core
//   flags_out  - time-code control flags
//   tick_out   - tick request, high while a transfer is outstanding
//   tick_ack   - one-cycle acceptance strobe from the SpaceWire core
// ---------------------------------------------------------------------------
module jaxa_timecode_ctrl #(
  parameter int DATA_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] time_out,
  output logic [1:0]        flags_out,
  output logic              tick_out,
  input  logic              tick_ack
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Timer value on the last permitted un-acknowledged REQ cycle.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [15:0]       timer;
  logic [DATA_W-1:0] time_reg;
  logic              auto_inc;
  logic [1:0]        flags;
  logic              pending;
  logic              toerr;

  logic              wr;
  logic              wr_time;
  logic              wr_ctrl;
  logic              wr_status;
  logic              send_req;
  logic              period_fire;
  logic              start_req;
  logic [15:0]       period_rd;

  logic              start;
  logic              acked;
  logic              expired;

  // Register decode
  assign wr        = chipselect & ~write_n;
  assign wr_time   = wr & (address == 2'd0);
  assign wr_ctrl   = wr & (address == 2'd1);
  assign wr_status = wr & (address == 2'd2);
  assign send_req  = wr_ctrl & writedata[0];
  assign start_req = send_req | period_fire;

  // Not every writedata bit is meaningful for every DATA_W / build option.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

`ifdef JAXA_TIMECODE_PERIODIC_EN
  logic        wr_period;
  logic [15:0] period_reg;
  logic [15:0] period_cnt;

  assign wr_period = wr & (address == 2'd3);
  // A PERIOD write reloads the counter, so it suppresses a same-cycle expiry.
  assign period_fire = (period_reg != 16'd0) && (period_cnt == 16'd0) && !wr_period;
  assign period_rd   = period_reg;

  // PERIOD register and periodic down-counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_reg <= 16'd0;
      period_cnt <= 16'd0;
    end else if (wr_period) begin
      period_reg <= writedata[15:0];
      period_cnt <= (writedata[15:0] == 16'd0) ? 16'd0 : writedata[15:0] - 16'd1;
    end else if (period_reg != 16'd0) begin
      period_cnt <= (period_cnt == 16'd0) ? period_reg - 16'd1 : period_cnt - 16'd1;
    end else begin
      period_cnt <= period_cnt;
    end
  end
`else
  assign period_fire = 1'b0;
  assign period_rd   = 16'd0;
`endif

  // Next-state logic: start in IDLE, ack/timeout resolution in REQ
  always_comb begin
    state_next = state;
    start      = 1'b0;
    acked      = 1'b0;
    expired    = 1'b0;
    case (state)
      IDLE: begin
        if (start_req || pending) begin
          start      = 1'b1;
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        // Acknowledge wins over a timeout landing on the same cycle.
        if (tick_ack) begin
          acked      = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          expired    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and REQ-cycle timer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= 16'd0;
    end else begin
      state <= state_next;
      timer <= ((state == REQ) && (state_next == REQ)) ? timer + 16'd1 : 16'd0;
    end
  end

  // TIME register; a software write overrides a same-cycle auto-increment
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      time_reg <= '0;
    end else if (wr_time) begin
      time_reg <= writedata[DATA_W-1:0];
    end else if (acked && auto_inc) begin
      time_reg <= time_reg + DATA_W'(1);
    end else begin
      time_reg <= time_reg;
    end
  end

  // CTRL register fields
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      auto_inc <= 1'b0;
      flags    <= 2'd0;
    end else if (wr_ctrl) begin
      auto_inc <= writedata[1];
      flags    <= writedata[3:2];
    end else begin
      auto_inc <= auto_inc;
      flags    <= flags;
    end
  end

  // Presented time-code, captured only at a start so TIME writes while busy
  // do not disturb the transfer in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      time_out  <= '0;
      flags_out <= 2'd0;
    end else if (start) begin
      time_out  <= time_reg;
      flags_out <= wr_ctrl ? writedata[3:2] : flags;
    end else begin
      time_out  <= time_out;
      flags_out <= flags_out;
    end
  end

  // PENDING: one queued start while busy; additional requests are dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (start) begin
      pending <= 1'b0;
    end else if ((state == REQ) && start_req) begin
      pending <= 1'b1;
    end else begin
      pending <= pending;
    end
  end

  // TOERR: sticky timeout flag; a new timeout wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      toerr <= 1'b0;
    end else if (expired) begin
      toerr <= 1'b1;
    end else if (wr_status && writedata[2]) begin
      toerr <= 1'b0;
    end else begin
      toerr <= toerr;
    end
  end

  assign tick_out = (state == REQ);

  // Combinational register read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata[DATA_W-1:0] = time_reg;
      2'd1: readdata[3:0]        = {flags, auto_inc, 1'b0};
      2'd2: readdata[2:0]        = {toerr, pending, (state == REQ)};
      2'd3: readdata[15:0]       = period_rd;
      default: readdata = 32'd0;
    endcase
  end

endmodule
